// File: rtl/reg_in_unit.sv
// Input register unit: synchronises 16 board input ports, captures them, tracks
// per-port change flags and serves values/flags over a single-cycle read port.

module reg_in_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] pin,
    input  logic         clr,
    input  logic         rd_hit,
    output logic [W-1:0] cur,
    output logic         flag,
    output logic         flag_nxt
);
    logic [W-1:0] sync1, sync2;
    logic         chg;

    assign chg = (sync2 != cur);

    // A fresh change outranks both the bus clear and a destructive read.
    always_comb begin
        flag_nxt = flag;
        if (chg)
            flag_nxt = 1'b1;
        else if (clr)
            flag_nxt = 1'b0;
        else if (rd_hit)
            flag_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            cur   <= '0;
            flag  <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            cur   <= sync2;
            flag  <= flag_nxt;
        end
    end
endmodule

module reg_in_unit #(
    parameter int N_PORTS = 16,
    parameter int W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_PORTS*W-1:0] data_in_from_buf,
    input  logic                 rd_req,
    input  logic [4:0]           rd_addr,
    input  logic                 clr,
    input  logic [N_PORTS-1:0]   irq_mask,
    output logic                 rd_ack,
    output logic [15:0]          rd_data,
    output logic                 irq
);
    logic [N_PORTS-1:0][W-1:0] pins, cur;
    logic [N_PORTS-1:0]        flag, flag_nxt, rd_hit;
    logic [15:0]               rd_nxt;

    assign pins = data_in_from_buf;

    for (genvar k = 0; k < N_PORTS; k++) begin : g_lane
        assign rd_hit[k] = rd_req && !rd_addr[4] && (rd_addr[3:0] == 4'(k));

        reg_in_lane #(.W(W)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .pin      (pins[k]),
            .clr      (clr),
            .rd_hit   (rd_hit[k]),
            .cur      (cur[k]),
            .flag     (flag[k]),
            .flag_nxt (flag_nxt[k])
        );
    end

    // Port reads return the pre-edge flag and value; the summary read is non-destructive.
    always_comb begin
        rd_nxt = '0;
        if (!rd_addr[4])
            rd_nxt = {flag[rd_addr[3:0]], 7'b0, cur[rd_addr[3:0]]};
        else if (rd_addr == 5'd16)
            rd_nxt = flag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ack  <= 1'b0;
            rd_data <= '0;
            irq     <= 1'b0;
        end else begin
            rd_ack <= rd_req;
            if (rd_req)
                rd_data <= rd_nxt;
            irq <= |(flag_nxt & irq_mask);
        end
    end
endmodule

// File: tb/tb_reg_in_unit.sv
// Scoreboard bench for reg_in_unit: expected read data is queued when a read is
// issued and checked when rd_ack appears.

module tb_reg_in_unit;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] pins;
    logic         rd_req;
    logic [4:0]   rd_addr;
    logic         clr;
    logic [15:0]  irq_mask;
    logic         rd_ack;
    logic [15:0]  rd_data;
    logic         irq;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    reg_in_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data_in_from_buf (pins),
        .rd_req           (rd_req),
        .rd_addr          (rd_addr),
        .clr              (clr),
        .irq_mask         (irq_mask),
        .rd_ack           (rd_ack),
        .rd_data          (rd_data),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pop one expectation per ack, sampled clear of the active edge.
    always @(posedge clk) begin
        #2;
        if (rd_ack) begin
            if (exp_q.size() == 0)
                chk("spurious_ack", 32'(rd_ack), 32'd0);
            else
                chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic set_port(input int k, input logic [7:0] v);
        pins[k*8 +: 8] = v;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called just after a negedge; the request is sampled at the next posedge.
    task automatic do_read(input logic [4:0] a, input logic [15:0] e);
        rd_req  = 1'b1;
        rd_addr = a;
        exp_q.push_back(e);
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        pins     = '1;
        rd_req   = 1'b0;
        rd_addr  = '0;
        clr      = 1'b0;
        irq_mask = '0;

        // Reset with all pins high, then 0->FF registers as a change everywhere
        wait_neg(3);
        chk("rst_ack", 32'(rd_ack), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        wait_neg(3);
        do_read(5'd16, 16'hFFFF);
        pulse_clr();
        do_read(5'd16, 16'h0000);

        // Basic read, repeat read, irq drop
        irq_mask = 16'h0008;
        set_port(3, 8'hA5);
        wait_neg(3);
        chk("irq_set", 32'(irq), 32'd1);
        do_read(5'd3, 16'h80A5);
        chk("irq_clr", 32'(irq), 32'd0);
        do_read(5'd3, 16'h00A5);

        // Back-to-back reads including summary and reserved address
        set_port(0, 8'h11);
        set_port(1, 8'h22);
        set_port(5, 8'h55);
        wait_neg(3);
        rd_req = 1'b1;
        rd_addr = 5'd0;  exp_q.push_back(16'h8011); @(negedge clk);
        rd_addr = 5'd1;  exp_q.push_back(16'h8022); @(negedge clk);
        rd_addr = 5'd16; exp_q.push_back(16'h0020); @(negedge clk);
        rd_addr = 5'd20; exp_q.push_back(16'h0000); @(negedge clk);
        rd_req = 1'b0;
        chk("b2b_irq", 32'(irq), 32'd0);
        pulse_clr();

        // Change lands on the same edge as a read of that port
        set_port(7, 8'h3C);
        wait_neg(2);
        do_read(5'd7, 16'h00FF);
        do_read(5'd16, 16'h0080);
        do_read(5'd7, 16'h803C);

        // clr coinciding with a change on port 2
        set_port(0, 8'h33);
        set_port(1, 8'h44);
        wait_neg(3);
        set_port(2, 8'h5A);
        wait_neg(2);
        clr = 1'b1;
        irq_mask = 16'h0004;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_chg_irq", 32'(irq), 32'd1);
        do_read(5'd16, 16'h0004);
        do_read(5'd2, 16'h805A);
        chk("clr_chg_irq_off", 32'(irq), 32'd0);

        // Async reset while a read is in flight
        pins = '0;
        wait_neg(3);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        rd_req  = 1'b1;
        rd_addr = 5'd16;
        exp_q.push_back(16'hFFFF);
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", 32'(rd_ack), 32'd0);
        chk("midrst_data", 32'(rd_data), 32'd0);
        chk("midrst_irq", 32'(irq), 32'd0);
        rd_req = 1'b0;
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(4);
        do_read(5'd16, 16'h0000);
        chk("post_rst_irq", 32'(irq), 32'd0);

        wait_neg(3);
        chk("q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_in_unit.md
# reg_in_unit

Input-side counterpart of the output register unit: samples 16 external 8-bit input buffers, synchronises them into the core clock domain and holds them in capture registers. It tracks per-port change flags and returns port values and flag status to the register bus through a single-cycle request/acknowledge read port. It raises a level interrupt while any enabled port has changed. It sits between the board input buffers and the same 16-bit register bus that drives the output unit.

## Interface
- N_PORTS, 16, number of 8-bit input ports (fixed at 16 for the address map below)
- W, 8, width of each port
- clk  input  1  core clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- data_in_from_buf  input  N_PORTS*W  flattened port pins, port k at bits [8k+7:8k], asynchronous to clk
- rd_req  input  1  read request, one cycle per read
- rd_addr  input  5  0..15 = port k value; 16 = change-flag summary; 17..31 = reserved
- clr  input  1  synchronous clear of all change flags (bus CLR)
- irq_mask  input  16  per-port interrupt enable, 1 = enabled
- rd_ack  output  1  read data valid strobe
- rd_data  output  16  read data
- irq  output  1  registered interrupt, level

## Operation
- Per port: two-stage synchroniser sync1 → sync2, then capture register cur, all W bits wide. Reset value of all three is 0.
- Every cycle: cur <= sync2. Port k is changed when sync2 != cur; this sets flag[k] on the same edge that updates cur.
- Flag precedence per port, per edge, highest first:
  1. New change sets the flag.
  2. clr clears the flag.
  3. A read of port k clears the flag.
  4. Otherwise the flag holds.
- Read decode on an edge with rd_req=1:
  - rd_addr 0..15: rd_data <= {flag[k], 7'b0, cur[k]}. Flag and cur values are those before the edge. Flag k is then cleared per the precedence rules.
  - rd_addr 16: rd_data <= flag[15:0]. Non-destructive; no flags are cleared.
  - rd_addr 17..31: rd_data <= 0. rd_ack still asserted.
- On an edge with rd_req=0: rd_ack <= 0 and rd_data holds its last value.
- irq <= |(flag & irq_mask), computed from the flag values after the current edge's update, registered.
- Reset (asynchronous, rst_n low) forces the following to 0 immediately, mid-read included:
  - sync1, sync2, cur, all flags
  - rd_ack, rd_data, irq
- After rst_n deasserts, a read in progress is lost and no ack is produced for it.
- clr has no effect on sync, cur or rd_data.

## Timing
- Read latency: rd_req sampled at edge n, so rd_ack=1 and rd_data are valid during cycle n+1 (one clock). rd_ack is high for exactly one cycle per request.
- Back-to-back reads: rd_req may stay high on consecutive cycles. Each cycle gets its own ack.
- A second read of the same port one cycle after the first returns flag=0, unless a new change landed in between.
- Pin to capture: a pin value stable before edge e appears in sync1 at e, sync2 at e+1, and cur plus flag at e+2. It is readable via a request sampled at e+3, returned in cycle e+4.
- Change to irq: flag set at edge e+2 gives irq=1 at edge e+2, because irq is registered from the post-update flag value.
- Simultaneous change and read of the same port on one edge:
  - rd_data carries the old cur and old flag.
  - The flag remains set, because the change wins.
  - cur takes the new value.
- Simultaneous change and clr: the flag is set.
- A pin pulse shorter than one clock may be missed; that is acceptable.

## Test plan
- Reset: drive all pins 8'hFF and hold rst_n low 3 cycles → rd_ack=0, rd_data=0, irq=0. After release plus 2 edges, flag summary read (addr 16) returns 16'hFFFF, because 0→FF is a change.
- Basic read: set port 3 = 8'hA5 and irq_mask=16'h0008. Wait for flag, then read addr 3 → next cycle rd_ack=1, rd_data=16'h80A5.
  - A repeat read returns 16'h00A5.
  - irq falls one edge after the first read.
- Back-to-back: rd_req held high 4 cycles with addr 0, 1, 16, 20 → four consecutive acks. The addr 20 ack carries 16'h0000, and the summary shows the flags of ports 0 and 1 already cleared.
- Collision: change port 7 on the same edge as a read of port 7 → returned flag bit is the old value. A subsequent summary read shows bit 7 = 1.
- clr vs change: assert clr on the same edge that port 2 changes → flag 2 stays 1 and all other flags become 0.
- Reset mid-read: pulse rst_n low while rd_req is active and asynchronous to clk → rd_ack drops immediately. No ack appears after release, and all flags are 0 until the pins change again.
